mips_state_dump: RTL and testbench
==================================

// Module: mips_state_dump
// PURPOSE
//  Synthesizable snapshot engine for the single-cycle MIPS processor. On a start pulse or
//  after a programmed cycle count, it freezes the core and streams a header word (PC),
//  then register-file contents, then data-memory contents, over a valid/ready channel.
//  Sits beside Processor and taps the RegFile and DataMem read ports, replacing bench dumps.
// PARAMETERS
//  DATA_W      32  width of PC, register and memory words
//  NREG        32  register-file entries dumped (indices 0..NREG-1)
//  MEM_DEPTH   32  data-memory words dumped (indices 0..MEM_DEPTH-1)
//  AUTO_CYCLES 75  core cycles after reset release before auto-dump; 0 disables auto-dump
//  IDX_W       derived localparam = $clog2(max(NREG,MEM_DEPTH)), min 1
// PORTS
//  clk        in   1      system clock, rising edge
//  rts        in   1      asynchronous, active-low reset
//  start      in   1      one-cycle request; sampled only in IDLE
//  mode       in   2      bit0 dump registers, bit1 dump memory; sampled with start
//  pc_in      in   DATA_W current PC of the core
//  rf_raddr   out  5      register-file read address (combinational read port)
//  rf_rdata   in   DATA_W register-file read data, same cycle
//  mem_raddr  out  IDX_W  data-memory word read address (combinational read port)
//  mem_rdata  in   DATA_W data-memory read data, same cycle
//  cpu_stall  out  1      freeze PC and all core writes while high
//  busy       out  1      dump in progress
//  done       out  1      one-cycle pulse after last beat accepted
//  out_valid  out  1      stream beat valid
//  out_ready  in   1      stream consumer ready
//  out_data   out  DATA_W beat payload
//  out_kind   out  2      0 header(PC), 1 register, 2 memory
//  out_index  out  IDX_W  register/memory index of the beat; 0 for header
//  out_last   out  1      final beat of the dump
// BEHAVIOUR
//  - Reset (rts=0): state IDLE; all outputs 0; cycle counter 0; auto_fired 0.
//  - FSM: IDLE -> HDR -> REGS -> MEMS -> FIN -> IDLE. REGS skipped if mode[0]=0; MEMS
//    skipped if mode[1]=0. FIN pulses done for one cycle, drops busy and cpu_stall.
//  - Trigger: start in IDLE, or counter == AUTO_CYCLES with auto_fired=0 (mode forced 2'b11).
//    Simultaneous start and auto trigger -> one dump, mode 2'b11; auto_fired set.
//    start outside IDLE is ignored. Counter increments only while IDLE and cpu_stall=0,
//    saturates at AUTO_CYCLES; auto-dump fires once per reset.
//  - cpu_stall and busy rise the cycle after the trigger; PC is latched into a header
//    register at the trigger edge so the header equals the PC seen at trigger.
//  - Output register: loads the next beat when (!out_valid || out_ready); beat transfers on
//    out_valid && out_ready. While out_valid && !out_ready, out_data/kind/index/last hold
//    stable. Addresses rf_raddr/mem_raddr equal the index of the beat being loaded.
//  - First beat (header) valid 1 cycle after trigger; with out_ready=1 continuously one
//    beat per cycle: total beats = 1 + NREG*mode[0] + MEM_DEPTH*mode[1].
//  - out_last on header when mode=0, else on index NREG-1 (REGS, mode=01) or MEM_DEPTH-1.
//  - Index counters wrap to 0 on state change; never exceed NREG-1 / MEM_DEPTH-1.
//  - rts asserted mid-dump: immediate return to IDLE, out_valid=0, cpu_stall=0, no done.
// STRUCTURE
//  - Package mips_dbg_pkg: typedef enum {IDLE,HDR,REGS,MEMS,FIN} dump_state_t; localparams
//    KIND_HDR=0, KIND_REG=1, KIND_MEM=2; MODE_REGS/MODE_MEM bit positions.
//  - One sub-module: mips_dump_outreg (DATA_W payload skid/hold register with valid/ready);
//    FSM, counters and trigger logic live in the top.
// TESTING
//  - Reset then start=1, mode=11, out_ready=1, PC=0x24 -> 65 beats: hdr 0x24, regs 0..31,
//    mem 0..31, out_last on mem index 31, done pulse next cycle, busy/stall low after.
//  - mode=01, out_ready toggled 1/0 every cycle -> 33 beats, payload stable during stalls,
//    out_last on reg index 31, no memory beats.
//  - mode=00 -> single header beat with out_last=1, done one cycle after acceptance.
//  - AUTO_CYCLES=75, no start -> trigger after exactly 75 IDLE cycles, mode 11; no second
//    auto-dump after 500 further cycles; start then still produces a full dump.
//  - rts pulled low at beat 10 of a dump -> all outputs 0 same time, no done; new start
//    after release gives full dump from header.
//  - start during busy and start coincident with auto trigger -> exactly one dump each case.

Source files
------------

// File: rtl/mips_dbg_pkg.sv
// Shared types and constants for the MIPS state-dump snapshot engine.
package mips_dbg_pkg;

    typedef enum logic [2:0] {IDLE, HDR, REGS, MEMS, FIN} dump_state_t;

    localparam logic [1:0] KIND_HDR = 2'd0;
    localparam logic [1:0] KIND_REG = 2'd1;
    localparam logic [1:0] KIND_MEM = 2'd2;

    localparam int MODE_REGS = 0;
    localparam int MODE_MEM  = 1;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mips_dump_outreg.sv
// Output beat register for the dump stream: accepts a new beat whenever it is empty or
// its current beat is being taken, otherwise holds payload stable.
module mips_dump_outreg #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rts,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_kind,
    input  logic [IDX_W-1:0]  in_index,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_kind,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_last
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_kind;
    logic [IDX_W-1:0]  r_index;
    logic              r_last;

    assign in_ready = !r_valid || out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rts) begin
        if (!rts) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_kind  <= '0;
            r_index <= '0;
            r_last  <= 1'b0;
        end else if (in_ready) begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_data  <= in_data;
                r_kind  <= in_kind;
                r_index <= in_index;
                r_last  <= in_last;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_kind  = r_kind;
    assign out_index = r_index;
    assign out_last  = r_last;

endmodule

// File: rtl/mips_state_dump.sv
// Snapshot engine: freezes the MIPS core and streams PC, register file and data memory
// over a valid/ready channel, on request or once after a programmed number of cycles.
module mips_state_dump
    import mips_dbg_pkg::*;
#(
    parameter int  DATA_W      = 32,
    parameter int  NREG        = 32,
    parameter int  MEM_DEPTH   = 32,
    parameter int  AUTO_CYCLES = 75,
    localparam int IDX_W       = clog2_min1((NREG > MEM_DEPTH) ? NREG : MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rts,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] pc_in,
    output logic [4:0]        rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [IDX_W-1:0]  mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_stall,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_kind,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_last
);

    localparam int               CNT_W    = clog2_min1(AUTO_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(AUTO_CYCLES);
    localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(NREG - 1);
    localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_DEPTH - 1);

    dump_state_t      r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic             r_auto_fired;

    logic              w_auto, w_trig;
    logic [1:0]        w_mode_eff;
    logic              w_beat_valid, w_beat_last, w_load_ready, w_in_phase;
    logic [1:0]        w_beat_kind;
    logic [IDX_W-1:0]  w_beat_idx;
    logic [DATA_W-1:0] w_beat_data;

    assign w_auto     = (AUTO_CYCLES != 0) && (r_state == IDLE) && (r_cnt == CNT_MAX)
                        && !r_auto_fired;
    assign w_trig     = (r_state == IDLE) && (start || w_auto);
    assign w_mode_eff = w_auto ? 2'b11 : mode;
    assign w_in_phase = (r_state == HDR) || (r_state == REGS) || (r_state == MEMS);

    // The "beat" signals describe the next beat to load into the output register.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned
        // and no latch is inferred.
        w_beat_valid = 1'b0;
        w_beat_kind  = KIND_HDR;
        w_beat_idx   = '0;
        w_beat_last  = 1'b0;
        w_state_nxt  = r_state;

        unique case (r_state)
            IDLE: begin
                if (w_trig) begin
                    w_beat_valid = 1'b1;
                    w_state_nxt  = HDR;
                end
            end
            HDR: begin
                if (r_mode[MODE_REGS]) begin
                    w_beat_valid = 1'b1;
                    w_beat_kind  = KIND_REG;
                end else if (r_mode[MODE_MEM]) begin
                    w_beat_valid = 1'b1;
                    w_beat_kind  = KIND_MEM;
                end
            end
            REGS: begin
                if (r_idx != REG_LAST) begin
                    w_beat_valid = 1'b1;
                    w_beat_kind  = KIND_REG;
                    w_beat_idx   = r_idx + 1'b1;
                end else if (r_mode[MODE_MEM]) begin
                    w_beat_valid = 1'b1;
                    w_beat_kind  = KIND_MEM;
                end
            end
            MEMS: begin
                if (r_idx != MEM_LAST) begin
                    w_beat_valid = 1'b1;
                    w_beat_kind  = KIND_MEM;
                    w_beat_idx   = r_idx + 1'b1;
                end
            end
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        unique case (w_beat_kind)
            KIND_REG: w_beat_last = (w_beat_idx == REG_LAST) && !r_mode[MODE_MEM];
            KIND_MEM: w_beat_last = (w_beat_idx == MEM_LAST);
            default:  w_beat_last = (w_mode_eff == 2'b00);
        endcase

        // Leaving a streaming phase happens only when the held beat is taken.
        if (w_in_phase && w_load_ready) begin
            if (!w_beat_valid)
                w_state_nxt = FIN;
            else if (w_beat_kind == KIND_REG)
                w_state_nxt = REGS;
            else
                w_state_nxt = MEMS;
        end
    end

    always_comb begin
        unique case (w_beat_kind)
            KIND_REG: w_beat_data = rf_rdata;
            KIND_MEM: w_beat_data = mem_rdata;
            default:  w_beat_data = pc_in;
        endcase
    end

    assign rf_raddr  = 5'(w_beat_idx);
    assign mem_raddr = w_beat_idx;

    always_ff @(posedge clk or negedge rts) begin
        if (!rts) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_mode       <= 2'b00;
            r_cnt        <= '0;
            r_auto_fired <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_beat_valid && w_load_ready)
                r_idx <= w_beat_idx;
            if (w_trig)
                r_mode <= w_mode_eff;
            if (w_auto)
                r_auto_fired <= 1'b1;
            if ((r_state == IDLE) && !cpu_stall && (r_cnt != CNT_MAX))
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign busy      = w_in_phase;
    assign cpu_stall = w_in_phase;
    assign done      = (r_state == FIN);

    mips_dump_outreg #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_outreg (
        .clk       (clk),
        .rts       (rts),
        .in_valid  (w_beat_valid),
        .in_ready  (w_load_ready),
        .in_data   (w_beat_data),
        .in_kind   (w_beat_kind),
        .in_index  (w_beat_idx),
        .in_last   (w_beat_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_kind  (out_kind),
        .out_index (out_index),
        .out_last  (out_last)
    );

endmodule

// File: tb/tb_mips_state_dump.sv
// Scoreboard bench for mips_state_dump: expected beat lists are queued at each trigger and
// a negedge monitor pops and compares every accepted beat, the done pulse and stalls.
module tb_mips_state_dump;

    localparam int DATA_W      = 32;
    localparam int NREG        = 32;
    localparam int MEM_DEPTH   = 32;
    localparam int AUTO_CYCLES = 75;
    localparam int IDX_W       = 5;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  kind;
        logic [4:0]  idx;
        logic        last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rts = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic [DATA_W-1:0] pc_in = '0;
    logic [4:0]        rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic [IDX_W-1:0]  mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic              cpu_stall, busy, done, out_valid, out_last;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_kind;
    logic [IDX_W-1:0]  out_index;

    logic [DATA_W-1:0] rf [NREG];
    logic [DATA_W-1:0] dm [MEM_DEPTH];

    beat_t sb_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    done_due = -1;
    int    n_acc = 0;
    int    rdy_mode = 0;

    always #5 clk = ~clk;

    assign rf_rdata  = rf[rf_raddr];
    assign mem_rdata = dm[mem_raddr];

    mips_state_dump #(
        .DATA_W      (DATA_W),
        .NREG        (NREG),
        .MEM_DEPTH   (MEM_DEPTH),
        .AUTO_CYCLES (AUTO_CYCLES)
    ) dut (
        .clk       (clk),
        .rts       (rts),
        .start     (start),
        .mode      (mode),
        .pc_in     (pc_in),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .cpu_stall (cpu_stall),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_kind  (out_kind),
        .out_index (out_index),
        .out_last  (out_last)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic randomize_env();
        for (int i = 0; i < NREG; i++) rf[i] = $urandom;
        for (int i = 0; i < MEM_DEPTH; i++) dm[i] = $urandom;
    endtask

    // Reference: a dump is the PC, then every selected register, then every selected
    // memory word, with the final element of that list flagged as last.
    task automatic push_dump(input logic [1:0] m, input logic [31:0] pc);
        int total = 1 + (m[0] ? NREG : 0) + (m[1] ? MEM_DEPTH : 0);
        int k = 1;
        sb_q.push_back({pc, 2'd0, 5'd0, (total == 1)});
        if (m[0])
            for (int i = 0; i < NREG; i++) begin
                k++;
                sb_q.push_back({rf[i], 2'd1, 5'(i), (k == total)});
            end
        if (m[1])
            for (int i = 0; i < MEM_DEPTH; i++) begin
                k++;
                sb_q.push_back({dm[i], 2'd2, 5'(i), (k == total)});
            end
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #3;
        rts   = 1'b0;
        start = 1'b0;
        #1;
        check("reset_outputs", {out_valid, busy, cpu_stall, done, out_data, out_kind,
                                out_index, out_last, rf_raddr, mem_raddr}, '0);
        sb_q.delete();
        done_due = -1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rts = 1'b1;
    endtask

    // Called one step after the trigger edge; exp_lat counts that edge as 1.
    task automatic wait_done(input int exp_lat, input int extra_at);
        int n = 1;
        while (!done && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            if (n == extra_at) begin
                start = 1'b1;
                mode  = 2'b01;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("done_seen", done, 1);
        if (exp_lat > 0) check("dump_latency", n, exp_lat);
        @(posedge clk);
        #1;
        check("idle_after", {busy, cpu_stall, done, out_valid}, 4'b0000);
        check("sb_drained", sb_q.size(), 0);
    endtask

    task automatic do_dump(input logic [1:0] m, input logic [31:0] pc,
                           input int exp_lat, input int extra_at);
        @(posedge clk);
        #1;
        randomize_env();
        pc_in = pc;
        mode  = m;
        start = 1'b1;
        n_acc = 0;
        push_dump(m, pc);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("trigger_resp", {busy, cpu_stall, out_valid}, 3'b111);
        wait_done(exp_lat, extra_at);
    endtask

    initial begin : ready_drv
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = !out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : monitor
        beat_t got, held, exp_b;
        logic  hold;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rts) begin
                hold = 1'b0;
            end else begin
                got = {out_data, out_kind, out_index, out_last};
                if (hold) check("hold_stable", {out_valid, got}, {1'b1, held});
                hold = out_valid && !out_ready;
                held = got;
                if (done || cyc == done_due)
                    check("done_pulse", {done, busy, cpu_stall}, {(cyc == done_due), 2'b00});
                if (out_valid && out_ready) begin
                    n_acc++;
                    if (sb_q.size() == 0) begin
                        check("extra_beat", {out_valid, out_ready}, 2'b00);
                    end else begin
                        exp_b = sb_q.pop_front();
                        check("beat", got, exp_b);
                        check("stall_during_beat", {busy, cpu_stall}, 2'b11);
                        if (exp_b.last) done_due = cyc + 1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        int bc;
        logic [1:0] m;

        // Auto-dump after reset with no start.
        rdy_mode = 0;
        reset_dut();
        pc_in = 32'h0040_0100;
        randomize_env();
        push_dump(2'b11, pc_in);
        n = 0;
        while (!busy && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("auto_trigger_cycle", n, AUTO_CYCLES + 1);
        check("auto_trigger_resp", {busy, cpu_stall, out_valid}, 3'b111);
        wait_done(1 + NREG + MEM_DEPTH + 1, 0);

        bc = 0;
        repeat (500) begin
            @(posedge clk);
            #1;
            if (busy) bc++;
        end
        check("no_second_auto", bc, 0);

        // Full dump, continuous ready.
        do_dump(2'b11, 32'h0000_0024, 1 + NREG + MEM_DEPTH + 1, 0);

        // Registers only, ready toggling every cycle.
        rdy_mode = 1;
        do_dump(2'b01, $urandom, -1, 0);

        // Header only.
        rdy_mode = 0;
        do_dump(2'b00, $urandom, 2, 0);

        // Random modes with random backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 4; i++) begin
            m = 2'($urandom_range(0, 3));
            do_dump(m, $urandom, -1, 0);
        end

        // A second start while busy must be ignored.
        rdy_mode = 0;
        do_dump(2'b11, $urandom, 1 + NREG + MEM_DEPTH + 1, 5);

        // Start coincident with the auto trigger gives one mode-11 dump.
        reset_dut();
        pc_in = $urandom;
        randomize_env();
        push_dump(2'b11, pc_in);
        repeat (AUTO_CYCLES) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        mode  = 2'b01;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("coincident_trigger", {busy, cpu_stall, out_valid}, 3'b111);
        wait_done(1 + NREG + MEM_DEPTH + 1, 0);

        // Reset in the middle of a dump, then a fresh full dump.
        @(posedge clk);
        #1;
        randomize_env();
        pc_in = $urandom;
        mode  = 2'b11;
        start = 1'b1;
        n_acc = 0;
        push_dump(2'b11, pc_in);
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (n_acc < 10 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("beat10_reached", (n_acc >= 10), 1);
        reset_dut();
        do_dump(2'b11, $urandom, 1 + NREG + MEM_DEPTH + 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
